// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory-side responder.
`timescale 1ns/1ps
package mem_responder_pkg;
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  localparam int WIDTH_DEF  = 16;
  localparam int IO_OUT_OFS = 0;
  localparam int IO_CYC_OFS = 1;
endpackage

// File: rtl/mem_responder_ram_sp.sv
// Synchronous single-port RAM, read-first, registered read data.
`timescale 1ns/1ps
module ram_sp #(
  parameter int WIDTH    = 16,
  parameter int ADDRBITS = 10
)(
  input  logic                clk,
  input  logic                we,
  input  logic [ADDRBITS-1:0] addr,
  input  logic [WIDTH-1:0]    din,
  output logic [WIDTH-1:0]    dout
);
  logic [WIDTH-1:0] mem [2**ADDRBITS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end
endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder: RAM, output register and cycle counter.
`timescale 1ns/1ps
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int             WIDTH    = WIDTH_DEF,
  parameter int             ADDRBITS = 10,
  parameter int             LATENCY  = 2,
  parameter logic [WIDTH-1:0] IO_BASE = 16'hFF00
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             we,
  input  logic [WIDTH-1:0] address,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             ready,
  output logic             err,
  output logic             busy,
  output logic [WIDTH-1:0] io_out
);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [WIDTH-1:0] OUT_ADDR =
    IO_BASE + WIDTH'(IO_OUT_OFS);
  localparam logic [WIDTH-1:0] CYC_ADDR =
    IO_BASE + WIDTH'(IO_CYC_OFS);

  state_t               state;
  logic [CW-1:0]        count;
  logic [WIDTH-1:0]     addr_q;
  logic [WIDTH-1:0]     wdata_q;
  logic                 we_q;
  logic [WIDTH-1:0]     cycles;
  logic [WIDTH-1:0]     ram_dout;
  logic [WIDTH-1:0]     load_val;
  logic [ADDRBITS-1:0]  ram_addr;
  logic                 ram_we;
  logic                 hit_ram;
  logic                 hit_out;
  logic                 hit_cyc;
  logic                 access;
  logic                 bad;

  assign hit_ram = (addr_q[WIDTH-1:ADDRBITS] == '0);
  assign hit_out = (addr_q == OUT_ADDR);
  assign hit_cyc = (addr_q == CYC_ADDR);
  assign access  = (state == WAIT) && (count == '0);
  assign ram_we  = access && we_q && hit_ram;
  assign busy    = (state != IDLE);

  // Present the incoming address while idle so read data is ready by
  // the access edge even with a single wait state.
  assign ram_addr = (state == IDLE) ? address[ADDRBITS-1:0]
                                    : addr_q[ADDRBITS-1:0];

  assign bad = we_q ? !(hit_ram || hit_out)
                    : !(hit_ram || hit_out || hit_cyc);

  always_comb begin
    load_val = '0;
    unique case (1'b1)
      hit_ram: load_val = ram_dout;
      hit_out: load_val = io_out;
      hit_cyc: load_val = cycles;
      default: load_val = '0;
    endcase
  end

  ram_sp #(
    .WIDTH   (WIDTH),
    .ADDRBITS(ADDRBITS)
  ) u_ram (
    .clk (clk),
    .we  (ram_we),
    .addr(ram_addr),
    .din (wdata_q),
    .dout(ram_dout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cycles <= '0;
    else       cycles <= cycles + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata   <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
      io_out  <= '0;
    end else begin
      ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            addr_q  <= address;
            wdata_q <= wdata;
            we_q    <= we;
            count   <= CW'(LATENCY - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (count != '0) begin
            count <= count - 1'b1;
          end else begin
            state <= DONE;
            ready <= 1'b1;
            err   <= bad;
            if (!we_q)        rdata  <= load_val;
            else if (hit_out) io_out <= wdata_q;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder with a response scoreboard.
`timescale 1ns/1ps
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [15:0] address = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic [15:0] io_out;
  logic        ready;
  logic        err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] rd;
    logic        e;
    logic        scr;
  } vec_t;

  typedef struct {
    logic [15:0] rd;
    logic        e;
    logic        chk;
  } sb_t;

  sb_t  sbq[$];
  vec_t vecs[15];

  always #5 clk = ~clk;

  mem_responder #(
    .WIDTH   (16),
    .ADDRBITS(10),
    .LATENCY (2),
    .IO_BASE (16'hFF00)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .we     (we),
    .address(address),
    .wdata  (wdata),
    .rdata  (rdata),
    .ready  (ready),
    .err    (err),
    .busy   (busy),
    .io_out (io_out)
  );

  task automatic check(input string name,
                       input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    sb_t s;
    if (!reset && ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got ready=1, expected 0");
      end else begin
        s = sbq.pop_front();
        check("sb_err", 16'(err), 16'(s.e));
        if (s.chk) check("sb_rdata", rdata, s.rd);
      end
    end
  end

  task automatic run_xact(input logic w,
                          input logic [15:0] a,
                          input logic [15:0] d,
                          input logic [15:0] exp_rd,
                          input logic exp_e,
                          input logic chk,
                          input logic scr,
                          input string name);
    int lat;
    int bc;
    @(posedge clk); #1;
    req = 1'b1; we = w; address = a; wdata = d;
    sbq.push_back('{exp_rd, exp_e, chk});
    lat = 0;
    bc = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) req = 1'b0;
      if (busy) bc++;
      if (scr && !ready) begin
        address = 16'($urandom);
        wdata   = 16'($urandom);
      end
    end while (!ready && lat < 10);
    check({name, "_latency"}, 16'(lat), 16'd3);
    check({name, "_busy"}, 16'(bc), 16'd3);
  endtask

  initial begin
    logic [15:0] got[2];
    int          at[2];
    int          n;
    int          lat;

    vecs[0]  = '{1'b1, 16'h0000, 16'h0ABC, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 16'h0005, 16'hBEEF, 16'h0000, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 16'hFF00, 16'h00A5, 16'hBEEF, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 16'hFF00, 16'h0000, 16'h00A5, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 16'h0400, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 16'h0400, 16'h1111, 16'h0000, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 16'h0000, 16'h0000, 16'h0ABC, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 16'h0010, 16'h5555, 16'h0ABC, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 16'h03FF, 16'h7777, 16'h0ABC, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 16'h03FF, 16'h0000, 16'h7777, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 16'hFF02, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 16'h1005, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 16'h0005, 16'h2222, 16'h0000, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 16'h0005, 16'h0000, 16'h2222, 1'b0, 1'b0};

    #12;
    check("rst_rdata", rdata, 16'h0000);
    check("rst_ready", 16'(ready), 16'h0000);
    check("rst_err", 16'(err), 16'h0000);
    check("rst_io_out", io_out, 16'h0000);
    check("rst_busy", 16'(busy), 16'h0000);
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (vecs[i]) begin
      run_xact(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].rd,
               vecs[i].e, 1'b1, vecs[i].scr, $sformatf("vec%0d", i));
      if (i == 3) check("io_out_done", io_out, 16'h00A5);
    end
    check("io_out_kept", io_out, 16'h00A5);

    // Reset during WAIT of a store: nothing must commit or complete.
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; address = 16'h0010; wdata = 16'h1234;
    @(posedge clk); #1;
    req = 1'b0;
    check("abort_busy_before", 16'(busy), 16'h0001);
    reset = 1'b1;
    #1;
    check("abort_rdata", rdata, 16'h0000);
    check("abort_ready", 16'(ready), 16'h0000);
    check("abort_err", 16'(err), 16'h0000);
    check("abort_io_out", io_out, 16'h0000);
    check("abort_busy", 16'(busy), 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    run_xact(1'b0, 16'hFF01, 16'h0000, 16'd3, 1'b0, 1'b1, 1'b0,
             "cyc_after_reset");
    run_xact(1'b0, 16'h0010, 16'h0000, 16'h5555, 1'b0, 1'b1, 1'b0,
             "abort_dropped");

    // Back-to-back counter loads with req held high.
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; address = 16'hFF01; wdata = 16'h0000;
    sbq.push_back('{16'h0000, 1'b0, 1'b0});
    sbq.push_back('{16'h0000, 1'b0, 1'b0});
    n = 0;
    lat = 0;
    got[0] = '0; got[1] = '0;
    at[0] = 0; at[1] = 0;
    while (n < 2 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (ready) begin
        got[n] = rdata;
        at[n]  = lat;
        n++;
      end
    end
    req = 1'b0;
    check("b2b_count", 16'(n), 16'd2);
    check("b2b_first", 16'(at[0]), 16'd3);
    check("b2b_spacing", 16'(at[1] - at[0]), 16'd4);
    check("b2b_cyc_delta", got[1] - got[0], 16'd4);

    run_xact(1'b1, 16'hFF01, 16'hDEAD, got[1], 1'b1, 1'b1, 1'b0,
             "cyc_store");
    run_xact(1'b0, 16'hFF01, 16'h0000, got[1] + 16'd8, 1'b0,
             1'b1, 1'b0, "cyc_still_counts");
    check("io_out_after_rst", io_out, 16'h0000);

    repeat (4) @(posedge clk);
    #1;
    check("sb_drained", 16'(sbq.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
